// File: rtl/alu_sweep_bist.sv
// alu_sweep_bist: stimulus/capture engine that sits beside an N-bit ALU.
// Holds one operand pair on the ALU inputs and steps the opcode from 0 to 15.
// Each opcode is held for SETTLE cycles before Y/status are sampled. The
// sampled result is offered on a valid/ready stream and folded into a 16-bit
// MISR signature.
//
// Optional feature (macro SWEEP_OPERAND_INC_EN): adds an 8-bit 'passes' input.
// Several sweeps are run back to back. Between sweeps A is incremented and B
// is decremented.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a sweep (only honoured in IDLE)
//   a_seed, b_seed      operand pair for the sweep
//   passes              number of sweeps, 0 treated as 1 (optional feature only)
//   busy, done          busy in WAIT/EMIT; done is a one-cycle pulse at the end
//   alu_a/b/opcode      drive the ALU inputs
//   alu_y, alu_status   ALU outputs
//   res_valid/ready     result stream handshake
//   res_a/b/opcode/y/status  captured result fields
//   signature           MISR over {status, y} of every captured result
module alu_sweep_bist #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_seed,
  input  logic [N-1:0] b_seed,
`ifdef SWEEP_OPERAND_INC_EN
  input  logic [7:0]   passes,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_opcode,
  input  logic [N-1:0] alu_y,
  input  logic [4:0]   alu_status,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_a,
  output logic [N-1:0] res_b,
  output logic [3:0]   res_opcode,
  output logic [N-1:0] res_y,
  output logic [4:0]   res_status,
  output logic [15:0]  signature
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_EFF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

`ifdef SWEEP_OPERAND_INC_EN
  logic [7:0] passes_q;
  logic [7:0] pass_cnt;
`endif

  // Shift left with feedback taps 15/14/12/3, then fold in the data word.
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [15:0] d);
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fb} ^ d;
  endfunction

  // {status, y} zero-extended or truncated to the 16-bit MISR width.
  function automatic logic [15:0] misr_data(input logic [4:0] st, input logic [N-1:0] y);
    return 16'({st, y});
  endfunction

  assign busy = (state == S_WAIT) || (state == S_EMIT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_a      <= '0;
      res_b      <= '0;
      res_opcode <= '0;
      res_y      <= '0;
      res_status <= '0;
      signature  <= 16'h0000;
`ifdef SWEEP_OPERAND_INC_EN
      passes_q   <= 8'd0;
      pass_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_a      <= a_seed;
            alu_b      <= b_seed;
            alu_opcode <= 4'd0;
            signature  <= 16'hFFFF;
            cnt        <= CNT_RELOAD;
            state      <= S_WAIT;
`ifdef SWEEP_OPERAND_INC_EN
            passes_q   <= (passes == 8'd0) ? 8'd1 : passes;
            pass_cnt   <= 8'd0;
`endif
          end
        end
        S_WAIT: begin
          // cnt is never 0 here, so anything other than 1 keeps counting.
          if (cnt != CNT_W'(1)) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_a      <= alu_a;
            res_b      <= alu_b;
            res_opcode <= alu_opcode;
            res_y      <= alu_y;
            res_status <= alu_status;
            res_valid  <= 1'b1;
            signature  <= misr_next(signature, misr_data(alu_status, alu_y));
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          // Without ready everything holds, so the offered result stays stable.
          if (res_ready) begin
            res_valid <= 1'b0;
            if (alu_opcode == 4'hF) begin
`ifdef SWEEP_OPERAND_INC_EN
              if (pass_cnt + 8'd1 < passes_q) begin
                pass_cnt   <= pass_cnt + 8'd1;
                alu_a      <= alu_a + N'(1);
                alu_b      <= alu_b - N'(1);
                alu_opcode <= 4'd0;
                cnt        <= CNT_RELOAD;
                state      <= S_WAIT;
              end else begin
                state <= S_DONE;
              end
`else
              state <= S_DONE;
`endif
            end else begin
              alu_opcode <= alu_opcode + 4'd1;
              cnt        <= CNT_RELOAD;
              state      <= S_WAIT;
            end
          end
        end
        default: begin
          // DONE lasts exactly one cycle; start is ignored here.
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_bist.sv
// Directed testbench for alu_sweep_bist (N=8, SETTLE=2) with a behavioural
// ALU attached. The ALU can be replaced by a zero stub.
module tb_alu_sweep_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_seed = 8'd0;
  logic [7:0] b_seed = 8'd0;
`ifdef SWEEP_OPERAND_INC_EN
  logic [7:0] passes = 8'd0;
`endif
  logic       busy, done;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_opcode;
  logic [4:0] alu_status;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_a, res_b, res_y;
  logic [3:0] res_opcode;
  logic [4:0] res_status;
  logic [15:0] signature;

  logic stub = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [3:0] qop[$];
  logic [7:0] qy[$];
  logic [4:0] qs[$];

  always #5 clk = ~clk;

  alu_sweep_bist #(.N(8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_seed(a_seed), .b_seed(b_seed),
`ifdef SWEEP_OPERAND_INC_EN
    .passes(passes),
`endif
    .busy(busy), .done(done), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_status(alu_status), .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_opcode(res_opcode), .res_y(res_y),
    .res_status(res_status), .signature(signature)
  );

  // Behavioural ALU: returns {status[4:0], y[7:0]}.
  function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a, 1'b0};
      4'd7:    r = {a[0], 1'b0, a[7:1]};
      default: r = {1'b0, a ^ (b + {4'd0, op})};
    endcase
    return {r[8], (r[7:0] == 8'd0), r[7], ^r[7:0], op[0], r[7:0]};
  endfunction

  assign {alu_status, alu_y} = stub ? 13'd0 : alu_model(alu_a, alu_b, alu_opcode);

  // Expected signature after one full sweep of the behavioural ALU.
  function automatic logic [15:0] sig_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] s;
    logic [12:0] d;
    logic fb;
    s = 16'hFFFF;
    for (int op = 0; op < 16; op++) begin
      d  = alu_model(a, b, 4'(op));
      fb = s[15] ^ s[14] ^ s[12] ^ s[3];
      s  = {s[14:0], fb} ^ {3'b000, d};
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst && res_valid && res_ready) begin
      qa.push_back(res_a);
      qb.push_back(res_b);
      qop.push_back(res_opcode);
      qy.push_back(res_y);
      qs.push_back(res_status);
    end
    if (!rst && done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qop.delete(); qy.delete(); qs.delete();
  endtask

  task automatic start_sweep(input logic [7:0] a, input logic [7:0] b);
    a_seed = a;
    b_seed = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_opcode(input logic [3:0] op, input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (alu_opcode === op) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done, res_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/valid=%b required 000", {busy, done, res_valid});
    end
    vectors++;
    if (signature !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_sig: got %h required 0000", signature);
    end
    vectors++;
    if ({alu_a, alu_b, alu_opcode, res_a, res_b, res_opcode, res_y, res_status} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_data: nonzero data outputs after reset");
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sweep();
    int d0;
    int bad;
    clear_q();
    stub = 1'b0;
    res_ready = 1'b1;
    d0 = done_cnt;
    start_sweep(8'd3, 8'd7);
    for (int k = 0; k < 53; k++) begin
      vectors++;
      if (busy !== (k < 48)) begin
        miscompares++;
        $display("FAIL basic_busy k=%0d: got %b required %b", k, busy, (k < 48));
      end
      vectors++;
      if (done !== (k == 48)) begin
        miscompares++;
        $display("FAIL basic_done k=%0d: got %b required %b", k, done, (k == 48));
      end
      tick();
    end
    vectors++;
    if (qop.size() !== 16) begin
      miscompares++;
      $display("FAIL basic_count: got %0d results required 16", qop.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (qop[i] !== 4'(i) || qa[i] !== 8'd3 || qb[i] !== 8'd7 ||
            {qs[i], qy[i]} !== alu_model(8'd3, 8'd7, 4'(i))) bad++;
      end
      vectors++;
      if (bad !== 0) begin
        miscompares++;
        $display("FAIL basic_results: %0d bad results required 0", bad);
      end
    end
    vectors++;
    if (signature !== sig_ref(8'd3, 8'd7)) begin
      miscompares++;
      $display("FAIL basic_sig: got %h required %h", signature, sig_ref(8'd3, 8'd7));
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_signature();
    bit seen;
    stub = 1'b1;
    start_sweep(8'd3, 8'd7);
    wait_done(100, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL sig_timeout: done not seen required within 100 cycles");
    end
    vectors++;
    if (signature !== 16'h0F09) begin
      miscompares++;
      $display("FAIL sig_zero_alu: got %h required 0f09", signature);
    end
    tick();
    stub = 1'b0;
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [69:0] snap;
    clear_q();
    res_ready = 1'b1;
    start_sweep(8'h5A, 8'h3C);
    wait_opcode(4'd5, 40, seen);
    res_ready = 1'b0;
    for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_opcode !== 4'd5) begin
      miscompares++;
      $display("FAIL bp_hold_op: valid=%b opcode=%0d required 1/5", res_valid, res_opcode);
    end
    snap = {res_a, res_b, res_opcode, res_y, res_status, alu_a, alu_b, alu_opcode, signature, res_valid};
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({res_a, res_b, res_opcode, res_y, res_status, alu_a, alu_b, alu_opcode, signature,
           res_valid} !== snap) begin
        miscompares++;
        $display("FAIL bp_stable cycle %0d: outputs changed under backpressure", i);
      end
    end
    res_ready = 1'b1;
    tick();
    for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_opcode !== 4'd6) begin
      miscompares++;
      $display("FAIL bp_next_op: got %0d required 6", res_opcode);
    end
    wait_done(100, seen);
    vectors++;
    if (seen !== 1'b1 || qop.size() !== 16) begin
      miscompares++;
      $display("FAIL bp_complete: done=%b results=%0d required 1/16", seen, qop.size());
    end
    vectors++;
    if (signature !== sig_ref(8'h5A, 8'h3C)) begin
      miscompares++;
      $display("FAIL bp_sig: got %h required %h", signature, sig_ref(8'h5A, 8'h3C));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    int d0;
    res_ready = 1'b1;
    start_sweep(8'd3, 8'd7);
    wait_opcode(4'd7, 40, seen);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, done, res_valid, signature, alu_a, alu_b, alu_opcode,
         res_a, res_b, res_opcode, res_y, res_status} !== 73'd0) begin
      miscompares++;
      $display("FAIL rstmid_zero: busy=%b sig=%h op=%0d required all zero", busy, signature, alu_opcode);
    end
    rst = 1'b0;
    repeat (4) tick();
    vectors++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_nodone: done pulses=%0d busy=%b required 0/0", done_cnt - d0, busy);
    end
    clear_q();
    start_sweep(8'd1, 8'd2);
    vectors++;
    if (alu_opcode !== 4'd0 || alu_a !== 8'd1 || signature !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL rstmid_restart: op=%0d a=%0d sig=%h required 0/1/ffff", alu_opcode, alu_a, signature);
    end
    wait_done(100, seen);
    vectors++;
    if (seen !== 1'b1 || qop.size() !== 16 || qop[0] !== 4'd0 || qa[0] !== 8'd1) begin
      miscompares++;
      $display("FAIL rstmid_sweep: done=%b results=%0d required 1/16 from opcode 0", seen, qop.size());
    end
    tick();
  endtask

  task automatic test_start_busy();
    bit seen;
    int bad;
    clear_q();
    start_sweep(8'd3, 8'd7);
    wait_opcode(4'd3, 40, seen);
    a_seed = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, seen);
    bad = 0;
    foreach (qa[i]) if (qa[i] !== 8'd3) bad++;
    vectors++;
    if (seen !== 1'b1 || qa.size() !== 16 || bad !== 0) begin
      miscompares++;
      $display("FAIL busy_start: results=%0d bad res_a=%0d required 16/0", qa.size(), bad);
    end
    // start during the DONE cycle must not launch a sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_start: busy=%b required 0", busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || alu_a !== 8'd3 || res_opcode !== 4'd15) begin
      miscompares++;
      $display("FAIL done_hold: busy=%b a=%0d op=%0d required 0/3/15", busy, alu_a, res_opcode);
    end
  endtask

`ifdef SWEEP_OPERAND_INC_EN
  task automatic test_multipass();
    bit seen;
    int d0;
    clear_q();
    d0 = done_cnt;
    passes = 8'd2;
    start_sweep(8'd255, 8'd0);
    passes = 8'd0;
    wait_done(200, seen);
    vectors++;
    if (seen !== 1'b1 || qa.size() !== 32) begin
      miscompares++;
      $display("FAIL mp_count: done=%b results=%0d required 1/32", seen, qa.size());
    end else begin
      vectors++;
      if (qa[0] !== 8'd255 || qb[0] !== 8'd0 || qa[16] !== 8'd0 || qb[16] !== 8'd255 ||
          qop[16] !== 4'd0 || qop[31] !== 4'd15) begin
        miscompares++;
        $display("FAIL mp_operands: a0=%0d b0=%0d a16=%0d b16=%0d required 255/0/0/255",
                 qa[0], qb[0], qa[16], qb[16]);
      end
    end
    tick();
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL mp_done: got %0d pulses required 1", done_cnt - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_sweep();
    test_signature();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
`ifdef SWEEP_OPERAND_INC_EN
    test_multipass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sweep_bist.md
Name: alu_sweep_bist

Overview:
- Hardware stimulus/capture engine for the N-bit ALU (A, B, 4-bit Opcode -> Y, 5-bit status).
- Drives an operand pair through all 16 opcodes and waits a programmable settle time per opcode.
- Captures Y/status and streams each result out over a valid/ready interface.
- Folds every result into a 16-bit MISR signature for go/no-go self-test.
- Sits beside the ALU as its driving/observing end.

Parameters:
N, 8, ALU operand/result width.
SETTLE, 2, cycles the ALU inputs are held before sampling; value 0 behaves as 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin sweep; sampled only in IDLE.
a_seed  in  N  operand A for the sweep.
b_seed  in  N  operand B for the sweep.
busy  out  1  high in WAIT/EMIT.
done  out  1  one-cycle pulse after the last result handshake.
alu_a  out  N  to ALU A.
alu_b  out  N  to ALU B.
alu_opcode  out  4  to ALU Opcode.
alu_y  in  N  from ALU Y.
alu_status  in  5  from ALU status.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts.
res_a, res_b  out  N  operands of the captured result.
res_opcode  out  4  opcode of the captured result.
res_y  out  N  captured Y.
res_status  out  5  captured status.
signature  out  16  MISR value.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-sweep):
  - State goes to IDLE.
  - All outputs go to 0, including signature=16'h0000.
  - No done pulse is generated.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE, start=1:
  - alu_a<=a_seed, alu_b<=b_seed, alu_opcode<=0.
  - signature<=16'hFFFF, cnt<=max(SETTLE,1), go WAIT.
- WAIT, cnt>1: cnt<=cnt-1.
- WAIT, cnt==1:
  - res_a/res_b/res_opcode <= alu_a/alu_b/alu_opcode.
  - res_y<=alu_y, res_status<=alu_status.
  - res_valid<=1, MISR update, go EMIT.
- EMIT, res_ready=0: all res_* and alu_* are held stable. No signature update.
- EMIT, res_ready=1 (handshake):
  - res_valid<=0.
  - If alu_opcode==15: go DONE.
  - Else alu_opcode<=alu_opcode+1, cnt<=max(SETTLE,1), go WAIT.
- DONE: done=1 for exactly this cycle, then IDLE. alu_* and res_* data keep their last values.
- Timing: per opcode, SETTLE+1 edges with ready held high. With SETTLE=2, done is asserted in the cycle following edge start+48.
- start is ignored outside IDLE. start in the DONE cycle is ignored.
- MISR:
  - d = {alu_status, alu_y} zero-extended or truncated to 16 bits.
  - fb = s[15]^s[14]^s[12]^s[3].
  - s <= {s[14:0], fb} ^ d.
  - Updated only on the WAIT->EMIT capture edge.
- res_valid never drops without a handshake, except on reset.

Optional Feature:
SWEEP_OPERAND_INC_EN
- Defined:
  - Adds input passes (8 bits); passes=0 is treated as 1.
  - After the opcode-15 handshake, if fewer than passes sweeps are complete: alu_a<=alu_a+1, alu_b<=alu_b-1 (mod 2^N), alu_opcode<=0, go WAIT.
  - DONE only after the final pass. The signature accumulates across all passes.
- Undefined: the port is absent and exactly one sweep is run.

Test Plan:
1. Basic sweep: SETTLE=2, a_seed=3, b_seed=7, res_ready=1 -> 16 results, res_opcode 0..15 in order, res_a=3, res_b=7 each; busy high throughout; done single pulse at start+49 edges.
2. Signature check: stub ALU Y=0, status=0, sweep as in 1 -> signature=16'h0F09 at done.
3. Backpressure: res_ready=0 for 10 cycles while res_opcode=5 -> res_* and alu_opcode=5 stable, signature unchanged; release -> opcode 6 next, all 16 results still delivered.
4. Reset mid-sweep: rst pulse while alu_opcode=7 -> next cycle all outputs 0, busy=0, no done; new start with a_seed=1 -> sweep restarts at opcode 0.
5. Start while busy: start pulsed at opcode 3 with a_seed=9 -> ignored, res_a remains 3.
6. SWEEP_OPERAND_INC_EN, passes=2, a_seed=255, b_seed=0 -> 32 results; second pass res_a=0, res_b=255; single done at end.
